bpb_update_scheduler: RTL
=========================

// Module: bpb_update_scheduler
// PURPOSE
//  Collects branch-resolution updates from two execute-side requesters, arbitrates
//  them round-robin into a small FIFO and issues at most one update per cycle to
//  the branch prediction buffer (update/branch_result/buffer_addr/buffer_offset).
//  Sits between the execute stage and the prediction buffer; supports flush
//  (squash of queued updates) and hold (pause issue).
// PARAMETERS
//  FIFO_DEPTH    4  queued entries; power of 2, >= 2
//  ADDR_WIDTH    2  width of buffer_addr (buffer line index)
//  OFFSET_WIDTH  2  width of buffer_offset (bank select within line)
// PORTS
//  clock          in   1        single clock, all state on posedge
//  reset_n        in   1        asynchronous, active-low reset
//  req_valid      in   2        [i] requester i presents an update
//  req_ready      out  2        [i] requester i accepted this cycle (combinational)
//  req_addr0/1    in   ADDR_W   line index of requester 0/1
//  req_offset0/1  in   OFS_W    bank offset of requester 0/1
//  req_taken      in   2        [i] branch outcome of requester i (1 = taken)
//  flush          in   1        discard all queued and pending updates
//  hold           in   1        suppress issue; accepting continues
//  update         out  1        registered; one-cycle update strobe to buffer
//  branch_result  out  1        registered; taken bit of issued entry
//  buffer_addr    out  ADDR_W   registered; line index of issued entry
//  buffer_offset  out  OFS_W    registered; bank offset of issued entry
//  queue_count    out  log2(D)+1 registered FIFO occupancy
// BEHAVIOUR
//  - Reset (reset_n=0, async): FIFO empty, queue_count=0, update=0,
//    branch_result=0, buffer_addr=0, buffer_offset=0, rr_ptr=0.
//  - Arbitration: one push max per cycle. Both valid -> grant rr_ptr; one valid
//    -> grant it. After any accepted grant to i, rr_ptr <= ~i.
//  - req_ready[i] = grant[i] & (queue_count < FIFO_DEPTH) & !flush. No
//    pop-through: a full FIFO refuses even when popping that cycle.
//  - Transfer occurs when req_valid[i] & req_ready[i]; entry = {taken,addr,offset}.
//  - Issue: each posedge, if !flush & !hold & FIFO non-empty -> pop head into
//    output regs, update<=1; else update<=0, other outputs hold last value.
//  - Latency: accepted at edge k -> update=1 in cycle after edge k+1 (empty FIFO).
//  - Simultaneous push+pop: queue_count unchanged; order strictly FIFO.
//  - hold=1: update<=0 next cycle; entries retained; pushes continue until full.
//  - flush=1 (sync, highest priority): FIFO emptied, queue_count<=0, update<=0
//    next cycle, no request accepted that cycle; rr_ptr unchanged.
//  - Pointers wrap modulo FIFO_DEPTH; queue_count never exceeds FIFO_DEPTH.
//  - Reset mid-operation: all queued entries lost, outputs return to reset values.
//  - Same addr/offset may appear in consecutive issues; no merging or reordering.
// CONFIGURATION
//  BPB_UPD_BYPASS_EN defined: when FIFO empty, !hold, !flush and a request is
//    accepted, it is written directly to the output regs at that edge (update=1
//    in the cycle after acceptance edge k); FIFO not written, queue_count stays 0.
//    Bypass never applies when FIFO non-empty (ordering preserved).
//  Not defined: every accepted request passes through the FIFO (latency above).
// TESTING
//  1. Reset, req_valid=01 addr=2 ofs=1 taken=1 one cycle -> update=1, addr=2,
//     ofs=1, result=1 exactly one cycle, 2 edges after accept (1 with BYPASS).
//  2. req_valid=11 held 4 cycles, rr_ptr=0 -> grant order 0,1,0,1; issues
//     follow same order; req_ready never 11.
//  3. hold=1, push 5 updates with FIFO_DEPTH=4 -> 4 accepted, 5th req_ready=0,
//     queue_count=4, update=0; release hold -> 4 back-to-back updates, count->0.
//  4. queue_count=3, assert flush with req_valid=01 -> req_ready=00, next
//     cycle queue_count=0, update=0, no further issue.
//  5. Push/pop every cycle for 3*FIFO_DEPTH entries -> pointers wrap, issue
//     order equals accept order, queue_count constant at 1.
//  6. reset_n low mid-burst (count=2, update=1) -> outputs and count 0
//     immediately, no update after reset release until new request.

Source files
------------

// File: rtl/bpb_update_scheduler_if.sv
// Update-request and prediction-buffer write bundle for the BPB update scheduler.
// master = execute side / driver, slave = the scheduler itself.
interface bpb_update_scheduler_if #(
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_WIDTH   = 2,
    parameter int OFFSET_WIDTH = 2
);
    localparam int QCNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [ADDR_WIDTH-1:0]   req_addr0;
    logic [ADDR_WIDTH-1:0]   req_addr1;
    logic [OFFSET_WIDTH-1:0] req_offset0;
    logic [OFFSET_WIDTH-1:0] req_offset1;
    logic [1:0]              req_taken;
    logic                    flush;
    logic                    hold;
    logic                    update;
    logic                    branch_result;
    logic [ADDR_WIDTH-1:0]   buffer_addr;
    logic [OFFSET_WIDTH-1:0] buffer_offset;
    logic [QCNT_WIDTH-1:0]   queue_count;

    modport master (
        output req_valid, req_addr0, req_addr1, req_offset0, req_offset1, req_taken,
        output flush, hold,
        input  req_ready, update, branch_result, buffer_addr, buffer_offset, queue_count
    );

    modport slave (
        input  req_valid, req_addr0, req_addr1, req_offset0, req_offset1, req_taken,
        input  flush, hold,
        output req_ready, update, branch_result, buffer_addr, buffer_offset, queue_count
    );
endinterface

// File: rtl/bpb_update_scheduler.sv
// Round-robin arbitrates two branch-update requesters into a FIFO, issues one update per cycle.
// Latency: accept at edge k -> update high after edge k+1 (after edge k with BPB_UPD_BYPASS_EN).
// Backpressure: req_ready drops when FIFO is full (no pop-through) or on flush; hold pauses issue only.
module bpb_update_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_WIDTH   = 2,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    bpb_update_scheduler_if.slave   bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int QCNT_W = PTR_W + 1;

    typedef struct packed {
        logic                    taken;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [OFFSET_WIDTH-1:0] offset;
    } upd_t;

    upd_t              mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [QCNT_W-1:0] count;
    logic              rr_ptr;

    logic [1:0] grant;
    logic [1:0] ready;
    logic [1:0] accept;
    logic       can_push;
    logic       push;
    logic       pop;
    logic       bypass;
    logic       fifo_wr;
    upd_t       in_ent;

    logic                    upd_q;
    logic                    result_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [OFFSET_WIDTH-1:0] offset_q;

    always_comb begin
        grant = bus.req_valid;
        if (&bus.req_valid) begin
            grant = rr_ptr ? 2'b10 : 2'b01;
        end
        // A full FIFO refuses even when the head pops this same cycle.
        can_push = (count < QCNT_W'(FIFO_DEPTH)) && !bus.flush;
        ready    = can_push ? grant : 2'b00;
        accept   = bus.req_valid & ready;
        push     = |accept;

        in_ent.taken  = accept[1] ? bus.req_taken[1] : bus.req_taken[0];
        in_ent.addr   = accept[1] ? bus.req_addr1    : bus.req_addr0;
        in_ent.offset = accept[1] ? bus.req_offset1  : bus.req_offset0;

        pop = !bus.flush && !bus.hold && (count != '0);
`ifdef BPB_UPD_BYPASS_EN
        // Only an empty FIFO may be skipped, so issue order always matches accept order.
        bypass = push && (count == '0) && !bus.hold && !bus.flush;
`else
        bypass = 1'b0;
`endif
        fifo_wr = push && !bypass;
    end

    always_ff @(posedge clock) begin
        if (fifo_wr) begin
            mem[wr_ptr] <= in_ent;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fifo_wr, pop})
                2'b10:   count <= count + QCNT_W'(1);
                2'b01:   count <= count - QCNT_W'(1);
                default: count <= count;
            endcase
            if (accept[0]) begin
                rr_ptr <= 1'b1;
            end else if (accept[1]) begin
                rr_ptr <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            upd_q    <= 1'b0;
            result_q <= 1'b0;
            addr_q   <= '0;
            offset_q <= '0;
        end else if (pop) begin
            upd_q    <= 1'b1;
            result_q <= mem[rd_ptr].taken;
            addr_q   <= mem[rd_ptr].addr;
            offset_q <= mem[rd_ptr].offset;
        end else if (bypass) begin
            upd_q    <= 1'b1;
            result_q <= in_ent.taken;
            addr_q   <= in_ent.addr;
            offset_q <= in_ent.offset;
        end else begin
            upd_q <= 1'b0;
        end
    end

    assign bus.req_ready     = ready;
    assign bus.update        = upd_q;
    assign bus.branch_result = result_q;
    assign bus.buffer_addr   = addr_q;
    assign bus.buffer_offset = offset_q;
    assign bus.queue_count   = count;
endmodule
